// File: rtl/ctrl_seq_decoder.sv
// ctrl_seq_decoder: run-time writable opcode table issuing rep+1 registered control beats per
// accepted opcode over a valid/ready output, with flush and a wrapping retired counter.
module ctrl_seq_decoder #(
    parameter int OP_W   = 7,
    parameter int CTRL_W = 26,
    parameter int REP_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [OP_W-1:0]         cfg_addr,
    input  logic [CTRL_W+REP_W-1:0] cfg_data,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [REP_W-1:0]        out_beat,
    output logic                    out_last,
    output logic [CNT_W-1:0]        retired
);
    localparam int ENT_W = CTRL_W + REP_W;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state, state_nx;
    logic [ENT_W-1:0] dec_table [2**OP_W];
    logic [ENT_W-1:0] entry;
    logic [REP_W-1:0] rep;
    logic             done, accept;

    // Lookup reads the pre-edge table, so a same-cycle write to this entry is not yet visible
    assign entry     = dec_table[in_op];
    assign out_valid = state == EMIT;
    assign out_last  = out_valid && out_beat == rep;
    assign done      = out_valid && out_ready && out_last;
    assign in_ready  = !flush && (state == IDLE || done);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nx = flush ? IDLE : accept ? EMIT : done ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**OP_W; i++) dec_table[i] <= '0;
        end else if (cfg_we) begin
            dec_table[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ctrl <= '0;
            rep      <= '0;
            out_beat <= '0;
            retired  <= '0;
        end else begin
            if (accept) begin
                out_ctrl <= entry[CTRL_W-1:0];
                rep      <= entry[ENT_W-1:CTRL_W];
                out_beat <= '0;
            end else if (flush) begin
                out_beat <= '0;
            end else if (out_valid && out_ready && !out_last) begin
                out_beat <= out_beat + 1'b1;
            end
            // A last beat handshaking under flush does not count as retired
            if (done && !flush) retired <= retired + 1'b1;
        end
    end
endmodule

// File: tb/tb_ctrl_seq_decoder.sv
// tb_ctrl_seq_decoder: directed vector table, reset/wrap sequences and a queue-model random run.
module tb_ctrl_seq_decoder;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        cfg_we = 0;
    logic [6:0]  cfg_addr = 0;
    logic [28:0] cfg_data = 0;
    logic        flush = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [6:0]  in_op = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [25:0] out_ctrl;
    logic [2:0]  out_beat;
    logic        out_last;
    logic [15:0] retired;

    int errors = 0;
    int checks = 0;

    ctrl_seq_decoder dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_beat(out_beat),
        .out_last(out_last), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [28:0] data;
        logic        fl, iv;
        logic [6:0]  op;
        logic        ordy;
        logic        irdy, ov;
        logic [25:0] ctrl;
        logic [2:0]  beat;
        logic        last;
        logic [15:0] ret;
    } vec_t;

    typedef struct {
        logic [25:0] ctrl;
        logic [2:0]  beat;
        logic        last;
    } beat_t;

    vec_t  vecs[$];
    beat_t exp_q[$];
    logic [28:0] mtab [128];
    logic [15:0] m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic v(input logic we, input logic [6:0] addr, input logic [28:0] data,
                     input logic fl, input logic iv, input logic [6:0] op, input logic ordy,
                     input logic irdy, input logic ov, input logic [25:0] ctrl,
                     input logic [2:0] beat, input logic last, input logic [15:0] ret);
        vec_t r;
        r.we = we; r.addr = addr; r.data = data; r.fl = fl; r.iv = iv; r.op = op; r.ordy = ordy;
        r.irdy = irdy; r.ov = ov; r.ctrl = ctrl; r.beat = beat; r.last = last; r.ret = ret;
        vecs.push_back(r);
    endtask

    task automatic drive(input logic we, input logic [6:0] addr, input logic [28:0] data,
                         input logic fl, input logic iv, input logic [6:0] op, input logic ordy);
        cfg_we = we; cfg_addr = addr; cfg_data = data; flush = fl;
        in_valid = iv; in_op = op; out_ready = ordy;
    endtask

    task automatic do_reset();
        rst_n = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        // Expected outputs describe the cycle in which the row's inputs are applied
        v(0, 0, 0, 0, 0, 0, 1,              1, 0, 0, 0, 0, 0);
        v(1, 7'h05, {3'd0, 26'h2AAAAAA}, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 1, 7'h05, 1,          1, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 1,              1, 1, 26'h2AAAAAA, 0, 1, 0);
        v(1, 7'h10, {3'd3, 26'h123}, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0, 1, 7'h10, 1,          1, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0, 1, 7'h05, 1,          0, 1, 26'h123, 0, 0, 1);
        v(0, 0, 0, 0, 1, 7'h05, 1,          0, 1, 26'h123, 1, 0, 1);
        v(0, 0, 0, 0, 1, 7'h05, 1,          0, 1, 26'h123, 2, 0, 1);
        v(0, 0, 0, 0, 1, 7'h05, 1,          1, 1, 26'h123, 3, 1, 1);
        v(0, 0, 0, 0, 0, 0, 1,              1, 1, 26'h2AAAAAA, 0, 1, 2);
        v(0, 0, 0, 0, 0, 0, 1,              1, 0, 0, 0, 0, 3);
        // backpressure at beat 1 for four cycles
        v(0, 0, 0, 0, 1, 7'h10, 1,          1, 0, 0, 0, 0, 3);
        v(0, 0, 0, 0, 0, 0, 1,              0, 1, 26'h123, 0, 0, 3);
        for (int i = 0; i < 4; i++) v(0, 0, 0, 0, 0, 0, 0, 0, 1, 26'h123, 1, 0, 3);
        v(0, 0, 0, 0, 0, 0, 1,              0, 1, 26'h123, 1, 0, 3);
        v(0, 0, 0, 0, 0, 0, 1,              0, 1, 26'h123, 2, 0, 3);
        v(0, 0, 0, 0, 0, 0, 1,              1, 1, 26'h123, 3, 1, 3);
        v(0, 0, 0, 0, 0, 0, 1,              1, 0, 0, 0, 0, 4);
        // same-cycle write and lookup sees the old entry
        v(1, 7'h05, {3'd0, 26'h1}, 0, 1, 7'h05, 1, 1, 0, 0, 0, 0, 4);
        v(0, 0, 0, 0, 1, 7'h05, 1,          1, 1, 26'h2AAAAAA, 0, 1, 4);
        v(0, 0, 0, 0, 0, 0, 1,              1, 1, 26'h1, 0, 1, 5);
        v(0, 0, 0, 0, 0, 0, 1,              1, 0, 0, 0, 0, 6);
        // flush at beat 2, then normal issue
        v(0, 0, 0, 0, 1, 7'h10, 1,          1, 0, 0, 0, 0, 6);
        v(0, 0, 0, 0, 0, 0, 1,              0, 1, 26'h123, 0, 0, 6);
        v(0, 0, 0, 0, 0, 0, 1,              0, 1, 26'h123, 1, 0, 6);
        v(0, 0, 0, 1, 1, 7'h05, 1,          0, 1, 26'h123, 2, 0, 6);
        v(0, 0, 0, 0, 0, 0, 1,              1, 0, 0, 0, 0, 6);
        v(0, 0, 0, 0, 1, 7'h05, 1,          1, 0, 0, 0, 0, 6);
        v(0, 0, 0, 0, 0, 0, 1,              1, 1, 26'h1, 0, 1, 6);
        v(0, 0, 0, 0, 0, 0, 1,              1, 0, 0, 0, 0, 7);
        // flush coinciding with a last-beat handshake does not retire
        v(0, 0, 0, 0, 1, 7'h05, 1,          1, 0, 0, 0, 0, 7);
        v(0, 0, 0, 1, 0, 0, 1,              0, 1, 26'h1, 0, 1, 7);
        v(0, 0, 0, 0, 0, 0, 1,              1, 0, 0, 0, 0, 7);

        do_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].fl, vecs[i].iv, vecs[i].op,
                  vecs[i].ordy);
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].irdy));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("vec%0d retired", i), 32'(retired), 32'(vecs[i].ret));
            if (vecs[i].ov) begin
                chk($sformatf("vec%0d out_ctrl", i), 32'(out_ctrl), 32'(vecs[i].ctrl));
                chk($sformatf("vec%0d out_beat", i), 32'(out_beat), 32'(vecs[i].beat));
                chk($sformatf("vec%0d out_last", i), 32'(out_last), 32'(vecs[i].last));
            end
            @(posedge clk);
            #1;
        end

        // async reset in the middle of a multi-beat instruction
        drive(0, 0, 0, 0, 1, 7'h10, 1);
        @(posedge clk); #1 in_valid = 0;
        @(posedge clk); #2 rst_n = 0;
        #1;
        chk("async out_valid", 32'(out_valid), 0);
        chk("async retired", 32'(retired), 0);
        chk("async in_ready", 32'(in_ready), 1);
        #1 rst_n = 1;
        @(posedge clk); #1 drive(0, 0, 0, 0, 1, 7'h10, 1);
        @(posedge clk); #1 in_valid = 0;
        @(negedge clk);
        chk("post-reset out_valid", 32'(out_valid), 1);
        chk("post-reset out_ctrl", 32'(out_ctrl), 0);
        chk("post-reset out_last", 32'(out_last), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post-reset single beat", 32'(out_valid), 0);
        chk("post-reset retired", 32'(retired), 1);

        // retired counter wrap with back-to-back single-beat instructions
        do_reset();
        drive(0, 0, 0, 0, 1, 7'h33, 1);
        repeat (65536) @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        chk("wrap retired max", 32'(retired), 32'hFFFF);
        chk("wrap out_valid", 32'(out_valid), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap retired zero", 32'(retired), 0);

        // randomized run against a beat-queue model
        do_reset();
        foreach (mtab[i]) mtab[i] = '0;
        m_ret = 0;
        exp_q.delete();
        for (int c = 0; c < 2000; c++) begin
            logic exp_ir;
            drive($urandom_range(0, 3) == 0, 7'($urandom_range(0, 7)), 29'($urandom),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                  7'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_ir = !flush && (exp_q.size() == 0 || (out_ready && exp_q.size() == 1));
            chk("rnd in_ready", 32'(in_ready), 32'(exp_ir));
            chk("rnd out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("rnd retired", 32'(retired), 32'(m_ret));
            if (exp_q.size() != 0) begin
                chk("rnd out_ctrl", 32'(out_ctrl), 32'(exp_q[0].ctrl));
                chk("rnd out_beat", 32'(out_beat), 32'(exp_q[0].beat));
                chk("rnd out_last", 32'(out_last), 32'(exp_q[0].last));
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_ready && exp_q.size() != 0) begin
                    if (exp_q[0].last) m_ret++;
                    void'(exp_q.pop_front());
                end
                if (in_valid && exp_ir) begin
                    logic [28:0] e;
                    e = mtab[in_op];
                    for (int b = 0; b <= int'(e[28:26]); b++) begin
                        beat_t x;
                        x.ctrl = e[25:0];
                        x.beat = 3'(b);
                        x.last = b == int'(e[28:26]);
                        exp_q.push_back(x);
                    end
                end
            end
            if (cfg_we) mtab[cfg_addr] = cfg_data;
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
